lfsr_gen: RTL

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// Maximal-length XNOR Fibonacci LFSR with seed load, lockup-seed replacement,
// packed random-word output and full-period wrap detection.
module lfsr_gen #(
    parameter int WIDTH    = 10,
    parameter int OUT_BITS = 3
) (
    input  logic                Clock,
    input  logic                reset,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed,
    output logic [WIDTH-1:0]    q,
    output logic [OUT_BITS-1:0] rnd,
    output logic                rnd_valid,
    output logic                wrap,
    output logic                lockup_fix
);

    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_gen: WIDTH %0d outside legal range 3..16", WIDTH);
    end
    if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
        $error("lfsr_gen: OUT_BITS %0d outside legal range 1..WIDTH", OUT_BITS);
    end

    localparam int BCW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [BCW-1:0]   BIT_LAST  = BCW'(OUT_BITS - 1);
    localparam logic [WIDTH-1:0] STEP_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    // Tap positions as a bit mask (bit t-1 set for tap t); XNOR taps keep all-ones unreachable.
    function automatic logic [WIDTH-1:0] tap_mask();
        logic [15:0]      taps;
        logic [WIDTH-1:0] m;
        case (WIDTH)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = taps[i];
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] TAP_MASK = tap_mask();

    logic [WIDTH-1:0]    r_q;
    logic [OUT_BITS-1:0] r_rnd;
    logic                r_rnd_valid;
    logic                r_wrap;
    logic                r_lockup_fix;
    logic [BCW-1:0]      r_bit_cnt;
    logic [WIDTH-1:0]    r_step_cnt;

    logic                w_fb;
    logic [WIDTH-1:0]    w_q_next;
    logic                w_seed_locked;

    assign w_fb          = ~^(r_q & TAP_MASK);
    assign w_q_next      = {r_q[WIDTH-2:0], w_fb};
    assign w_seed_locked = &seed;

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge state.
        r_rnd_valid  <= 1'b0;
        r_wrap       <= 1'b0;
        r_lockup_fix <= 1'b0;
        if (reset) begin
            r_q        <= '0;
            r_rnd      <= '0;
            r_bit_cnt  <= '0;
            r_step_cnt <= '0;
        end else if (load) begin
            r_q          <= w_seed_locked ? '0 : seed;
            r_lockup_fix <= w_seed_locked;
            r_bit_cnt    <= '0;
            r_step_cnt   <= '0;
        end else if (en) begin
            r_q <= w_q_next;
            // A word is emitted only after OUT_BITS fresh shifts, so words never share bits.
            if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt   <= '0;
                r_rnd       <= w_q_next[OUT_BITS-1:0];
                r_rnd_valid <= 1'b1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_step_cnt == STEP_LAST) begin
                r_step_cnt <= '0;
                r_wrap     <= 1'b1;
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign q          = r_q;
    assign rnd        = r_rnd;
    assign rnd_valid  = r_rnd_valid;
    assign wrap       = r_wrap;
    assign lockup_fix = r_lockup_fix;

endmodule
